// File: rtl/input_debounce.sv
// input_debounce
//   Conditions a raw, asynchronous, possibly bouncing 1-bit input into a clean
//   clock-synchronous level.
//   - A SYNC_STAGES-deep flop chain brings a_raw_i into the clk domain.
//   - A 4-state FSM with a run-length counter accepts a new level only after
//     the synchronized input has held it for DEBOUNCE_CYCLES confirming
//     samples following entry to a check state.
//
// Optional feature (macro INPUT_DEBOUNCE_GLITCH_CNT_EN):
//   Adds the GLITCH_W parameter and the glitch_cnt_o port. The count is
//   incremented on each aborted qualification, saturates at all-ones, and is
//   cleared only by reset_n.
//
// Ports:
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   a_raw_i       in   raw asynchronous input
//   glitch_cnt_o  out  rejected-transition count (optional feature only)
//   a_o           out  debounced level, registered
//   busy_o        out  high while a candidate level change is being qualified
module input_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    ,
    parameter int GLITCH_W        = 8
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                a_raw_i,
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    output logic [GLITCH_W-1:0] glitch_cnt_o,
`endif
    output logic                a_o,
    output logic                busy_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_CHK_HIGH = 2'd1,
        S_HIGH     = 2'd2,
        S_CHK_LOW  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer: the FSM only ever looks at the last stage.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_raw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Stability FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              a_q, a_d;
    logic              busy_q, busy_d;
    logic              glitch_ev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        glitch_ev = 1'b0;

        case (state_q)
            S_LOW: begin
                if (s) begin
                    state_d = S_CHK_HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_CHK_HIGH: begin
                if (!s) begin
                    state_d   = S_LOW;
                    cnt_d     = '0;
                    glitch_ev = 1'b1;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_d = S_CHK_LOW;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_CHK_LOW: begin
                if (s) begin
                    state_d   = S_HIGH;
                    cnt_d     = '0;
                    glitch_ev = 1'b1;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they
        // line up with state_q and have no path from a_raw_i.
        a_d    = (state_d == S_HIGH) || (state_d == S_CHK_LOW);
        busy_d = (state_d == S_CHK_HIGH) || (state_d == S_CHK_LOW);
    end

    assign a_o    = a_q;
    assign busy_o = busy_q;

    // ------------------------------------------------------------------
    // Optional saturating glitch counter
    // ------------------------------------------------------------------
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_q <= '0;
        end else if (glitch_ev && (glitch_q != '1)) begin
            glitch_q <= glitch_q + GLITCH_W'(1);
        end
    end

    assign glitch_cnt_o = glitch_q;
`else
    logic unused_glitch_ev;
    assign unused_glitch_ev = glitch_ev;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce (default parameters).
// Reference model: a delay line of SYNC stages followed by a run-length rule
// -- the level flips once DB+1 consecutive opposite samples have been seen;
// an opposite run broken early counts as a glitch.
module tb_input_debounce;

    localparam int SYNC = 2;
    localparam int DB   = 4;
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    localparam int GW   = 2;
    localparam int GMAX = (1 << GW) - 1;
`else
    localparam int GMAX = 255;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic a_raw_i = 1'b0;
    logic a_o;
    logic busy_o;
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    logic [GW-1:0] glitch_cnt_o;
`endif

    always #5 clk = ~clk;

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    input_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .GLITCH_W(GW)) dut (
        .clk(clk), .reset_n(reset_n), .a_raw_i(a_raw_i),
        .glitch_cnt_o(glitch_cnt_o), .a_o(a_o), .busy_o(busy_o));
`else
    input_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset_n(reset_n), .a_raw_i(a_raw_i),
        .a_o(a_o), .busy_o(busy_o));
`endif

    int checks   = 0;
    int failures = 0;

    // model state
    bit hist [SYNC];
    bit m_level;
    int m_run;
    int m_glitch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
        m_level  = 1'b0;
        m_run    = 0;
        m_glitch = 0;
    endtask

    task automatic model_edge(input bit raw);
        bit s;
        s = hist[SYNC-1];
        for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = raw;
        if (s != m_level) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_level = s;
                m_run   = 0;
            end
        end else begin
            if (m_run > 0 && m_glitch < GMAX) m_glitch++;
            m_run = 0;
        end
    endtask

    // Drive one sample (also releases reset), clock it, compare to the model.
    task automatic step(input bit v);
        @(negedge clk);
        a_raw_i = v;
        reset_n = 1'b1;
        @(posedge clk);
        model_edge(v);
        #1;
        chk("a_o_model", a_o, m_level);
        chk("busy_model", busy_o, (m_run > 0));
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_model", glitch_cnt_o, m_glitch);
`endif
    endtask

    task automatic assert_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_a_o_now", a_o, 0);
        chk("rst_busy_now", busy_o, 0);
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        chk("rst_glitch_now", glitch_cnt_o, 0);
`endif
    endtask

    // Raw held at v from edge E0 (first step); a_o must reach v exactly at E0+6.
    task automatic qualify(input bit v, input string tag);
        for (int i = 0; i <= SYNC + DB; i++) begin
            step(v);
            if (i == 3) chk({tag, "_busy_mid"}, busy_o, 1);
            if (i == SYNC + DB - 1) chk({tag, "_a_early"}, a_o, !v);
            if (i == SYNC + DB) begin
                chk({tag, "_a_final"}, a_o, v);
                chk({tag, "_busy_final"}, busy_o, 0);
            end
        end
    endtask

    initial begin
        int  trans;
        bit  prev;
        bit  cur;
        int  runlen;
        model_reset();

        // Reset held with raw=1: outputs stay low across edges.
        reset_n = 1'b0;
        a_raw_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_a_o", a_o, 0);
            chk("rst_busy", busy_o, 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0);

        // Clean rise then settle.
        qualify(1'b1, "rise");
        step(1'b1);
        step(1'b1);

        // Clean fall: exactly one transition on a_o.
        trans = 0;
        prev  = a_o;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            if (a_o != prev) trans++;
            prev = a_o;
            if (i == SYNC + DB - 1) chk("fall_a_early", a_o, 1);
            if (i == SYNC + DB) chk("fall_a_final", a_o, 0);
        end
        chk("fall_transitions", trans, 1);

        // Bounce: 1,1,0,0,0 then held high.
        step(1'b1); step(1'b1); step(1'b0); step(1'b0); step(1'b0);
        chk("bounce_a_hold", a_o, 0);
        qualify(1'b1, "bounce");
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        chk("bounce_glitch", glitch_cnt_o, 1);
`endif
        step(1'b1);

        // Reset in the middle of a falling qualification.
        for (int i = 0; i < 4; i++) step(1'b0);
        chk("midq_busy_before", busy_o, 1);
        chk("midq_a_before", a_o, 1);
        assert_reset();
        a_raw_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("midq_a_held", a_o, 0);
        end
        qualify(1'b1, "midq");

        // Randomized runs with occasional asynchronous resets.
        cur = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 29) == 0) assert_reset();
            cur    = ($urandom_range(0, 2) != 0) ? !cur : cur;
            runlen = $urandom_range(1, 9);
            for (int k = 0; k < runlen; k++) step(cur);
        end

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
        // Saturation: five aborted qualifications.
        begin
            int exp_sat [5] = '{1, 2, 3, 3, 3};
            assert_reset();
            for (int i = 0; i < 4; i++) step(1'b0);
            for (int k = 0; k < 5; k++) begin
                step(1'b1); step(1'b0); step(1'b0); step(1'b0);
                chk("sat_glitch", glitch_cnt_o, exp_sat[k]);
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
